// File: rtl/winocnn_layer_sequencer.sv
// Layer sequencer for the Winograd convolution datapath: accepts one layer config,
// computes spatial block tiling, then walks every (input-channel, output-group) pass.
// Ports: cfg valid/ready + layer dims in; abort and loop_finished in; weight/data
// controller indices, lane mask, block counts, status flags and pass counter out.
module winocnn_layer_sequencer #(
    parameter int ID_W    = 4,
    parameter int OD_W    = 8,
    parameter int DIM_W   = 9,
    parameter int BLK_W   = 8,
    parameter int OD_PAR  = 2,
    parameter int TILE_IN = 6,
    parameter int STEP_T1 = 4,
    parameter int STEP_T0 = 6,
    parameter int PASS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [ID_W-1:0]   total_id_i,
    input  logic [OD_W-1:0]   total_od_i,
    input  logic [DIM_W-1:0]  total_width_i,
    input  logic [DIM_W-1:0]  total_height_i,
    input  logic              size_type_i,
    input  logic              abort_i,
    input  logic              loop_finished_i,
    output logic [OD_W-1:0]   weight_od_base_o,
    output logic [OD_PAR-1:0] od_lane_mask_o,
    output logic [ID_W-1:0]   weight_id_o,
    output logic [ID_W-1:0]   data_id_o,
    output logic [BLK_W-1:0]  block_width_o,
    output logic [BLK_W-1:0]  block_height_o,
    output logic              size_type_o,
    output logic              data_prepare_o,
    output logic              busy_o,
    output logic              conv_completed_o,
    output logic              cfg_err_o,
    output logic [PASS_W-1:0] pass_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_PREPARE, S_ADVANCE, S_DONE
    } state_t;

    localparam logic [DIM_W:0] TILE_X  = (DIM_W+1)'(TILE_IN);
    localparam logic [DIM_W:0] STEP1_X = (DIM_W+1)'(STEP_T1);
    localparam logic [DIM_W:0] STEP0_X = (DIM_W+1)'(STEP_T0);
    localparam logic [OD_W:0]  OD_PAR_X = (OD_W+1)'(OD_PAR);
    localparam int             BLK_MAX = (1 << BLK_W) - 1;

    state_t            state;
    logic [ID_W-1:0]   tot_id;
    logic [OD_W-1:0]   tot_od;
    logic [DIM_W-1:0]  tot_w;
    logic [DIM_W-1:0]  tot_h;
    logic              st;
    logic [ID_W-1:0]   id;
    logic [OD_W-1:0]   od_base;
    logic              last_grp;
    logic              last_id;
    logic              in_run;

    // Blocks along one dimension: a dimension that fits in a single input tile
    // (including 0) is one block; beyond that, ceil of the overhang over the stride.
    function automatic logic [BLK_W-1:0] blocks(input logic [DIM_W-1:0] d,
                                                input logic type_sel);
        logic [DIM_W:0] s;
        logic [DIM_W:0] q;
        s = type_sel ? STEP1_X : STEP0_X;
        if ({1'b0, d} <= TILE_X)
            return BLK_W'(1);
        q = (({1'b0, d} - TILE_X + s - (DIM_W+1)'(1)) / s) + (DIM_W+1)'(1);
        if (int'(q) > BLK_MAX)
            return BLK_W'(BLK_MAX);
        return BLK_W'(q);
    endfunction

    // Extra bit avoids wrap when od_base sits near the top of its range.
    assign last_grp = ({1'b0, od_base} + OD_PAR_X) >= {1'b0, tot_od};
    assign last_id  = ({1'b0, id} + (ID_W+1)'(1)) >= {1'b0, tot_id};
    assign in_run   = (state == S_CONFIG) || (state == S_PREPARE) || (state == S_ADVANCE);

    always_comb begin
        od_lane_mask_o = '0;
        for (int k = 0; k < OD_PAR; k++)
            od_lane_mask_o[k] = ({1'b0, od_base} + (OD_W+1)'(k)) < {1'b0, tot_od};
    end

    assign cfg_ready_o      = (state == S_IDLE) || (state == S_DONE);
    assign busy_o           = in_run;
    assign data_prepare_o   = (state == S_PREPARE);
    assign conv_completed_o = (state == S_DONE);
    assign weight_od_base_o = od_base;
    assign weight_id_o      = id;
    assign data_id_o        = id;
    assign size_type_o      = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            tot_id         <= '0;
            tot_od         <= '0;
            tot_w          <= '0;
            tot_h          <= '0;
            st             <= 1'b0;
            id             <= '0;
            od_base        <= '0;
            block_width_o  <= '0;
            block_height_o <= '0;
            cfg_err_o      <= 1'b0;
            pass_count_o   <= '0;
        end else if (abort_i && in_run) begin
            state        <= S_IDLE;
            id           <= '0;
            od_base      <= '0;
            pass_count_o <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_valid_i) begin
                        tot_id       <= total_id_i;
                        tot_od       <= total_od_i;
                        tot_w        <= total_width_i;
                        tot_h        <= total_height_i;
                        st           <= size_type_i;
                        id           <= '0;
                        od_base      <= '0;
                        pass_count_o <= '0;
                        cfg_err_o    <= 1'b0;
                        state        <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    block_width_o  <= blocks(tot_w, st);
                    block_height_o <= blocks(tot_h, st);
                    if ((tot_id == '0) || (tot_od == '0)) begin
                        cfg_err_o <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_PREPARE;
                    end
                end
                S_PREPARE: begin
                    if (loop_finished_i)
                        state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    pass_count_o <= pass_count_o + PASS_W'(1);
                    if (!last_grp) begin
                        od_base <= od_base + OD_W'(OD_PAR);
                        state   <= S_PREPARE;
                    end else if (!last_id) begin
                        od_base <= '0;
                        id      <= id + ID_W'(1);
                        state   <= S_PREPARE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_winocnn_layer_sequencer.sv
// Self-checking bench for winocnn_layer_sequencer: directed steps with a scoreboard
// of expected (id, od_base, lane mask) pass tuples, compared on each PREPARE cycle.
// Ports: drives every DUT input, observes every DUT output at the falling edge.
module tb_winocnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [3:0]  total_id_i;
    logic [7:0]  total_od_i;
    logic [8:0]  total_width_i;
    logic [8:0]  total_height_i;
    logic        size_type_i;
    logic        abort_i;
    logic        loop_finished_i;
    logic [7:0]  weight_od_base_o;
    logic [1:0]  od_lane_mask_o;
    logic [3:0]  weight_id_o;
    logic [3:0]  data_id_o;
    logic [7:0]  block_width_o;
    logic [7:0]  block_height_o;
    logic        size_type_o;
    logic        data_prepare_o;
    logic        busy_o;
    logic        conv_completed_o;
    logic        cfg_err_o;
    logic [15:0] pass_count_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    winocnn_layer_sequencer dut (
        .clk(clk), .reset(reset), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .total_id_i(total_id_i), .total_od_i(total_od_i), .total_width_i(total_width_i),
        .total_height_i(total_height_i), .size_type_i(size_type_i), .abort_i(abort_i),
        .loop_finished_i(loop_finished_i), .weight_od_base_o(weight_od_base_o),
        .od_lane_mask_o(od_lane_mask_o), .weight_id_o(weight_id_o), .data_id_o(data_id_o),
        .block_width_o(block_width_o), .block_height_o(block_height_o),
        .size_type_o(size_type_o), .data_prepare_o(data_prepare_o), .busy_o(busy_o),
        .conv_completed_o(conv_completed_o), .cfg_err_o(cfg_err_o),
        .pass_count_o(pass_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tuple(input int i, input int ob, input int m);
        return (32'(i) << 16) | (32'(ob) << 8) | 32'(m);
    endfunction

    // Reference pass order: output groups inner, input channels outer.
    task automatic push_passes(input int tid, input int tod);
        int m;
        for (int i = 0; i < tid; i++)
            for (int ob = 0; ob < tod; ob += 2) begin
                m = ((ob < tod) ? 1 : 0) | ((ob + 1 < tod) ? 2 : 0);
                sb.push_back(tuple(i, ob, m));
            end
    endtask

    function automatic logic [31:0] observed();
        return tuple(int'(weight_id_o), int'(weight_od_base_o), int'(od_lane_mask_o));
    endfunction

    task automatic send_cfg(input int tid, input int tod, input int w, input int h, input logic t);
        total_id_i     = 4'(tid);
        total_od_i     = 8'(tod);
        total_width_i  = 9'(w);
        total_height_i = 9'(h);
        size_type_i    = t;
        cfg_valid_i    = 1'b1;
        @(negedge clk);
        cfg_valid_i    = 1'b0;
    endtask

    task automatic wait_prepare();
        int n = 0;
        while (data_prepare_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("prepare_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic pop_compare(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(tag, observed(), e);
            check({tag, "_data_id"}, 32'(data_id_o), e >> 16);
        end
    endtask

    // Full run with one loop_finished pulse per PREPARE.
    task automatic run_cfg(input int tid, input int tod, input int w, input int h,
                           input logic t, input int bw, input int bh);
        int npass;
        npass = tid * ((tod + 1) / 2);
        push_passes(tid, tod);
        send_cfg(tid, tod, w, h, t);
        for (int p = 0; p < npass; p++) begin
            wait_prepare();
            if (p == 0) begin
                check("block_width", 32'(block_width_o), 32'(bw));
                check("block_height", 32'(block_height_o), 32'(bh));
                check("cfg_ready_busy", 32'(cfg_ready_o), 32'd0);
            end
            pop_compare("pass");
            loop_finished_i = 1'b1;
            @(negedge clk);
            loop_finished_i = 1'b0;
        end
        @(negedge clk);
        check("completed", 32'(conv_completed_o), 32'd1);
        check("pass_count", 32'(pass_count_o), 32'(npass));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_valid_i = 1'b0; abort_i = 1'b0; loop_finished_i = 1'b0;
        total_id_i = '0; total_od_i = '0; total_width_i = '0; total_height_i = '0;
        size_type_i = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cfg_ready_o), 32'd1);
        check("rst_outs", {busy_o, data_prepare_o, conv_completed_o, cfg_err_o, size_type_o,
                           od_lane_mask_o, weight_id_o, data_id_o}, 32'd0);
        check("rst_cnt", {pass_count_o, block_width_o, block_height_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic tiled run, partial final output group.
        run_cfg(2, 5, 13, 7, 1'b1, 3, 2);
        check("size_type_latched", 32'(size_type_o), 32'd1);

        // Block-count arithmetic across both tile modes.
        run_cfg(1, 1, 6, 6, 1'b0, 1, 1);
        run_cfg(1, 1, 12, 6, 1'b0, 2, 1);
        run_cfg(1, 1, 13, 6, 1'b0, 3, 1);
        run_cfg(1, 1, 60, 0, 1'b0, 10, 1);
        run_cfg(1, 1, 400, 6, 1'b0, 67, 1);
        run_cfg(1, 1, 42, 11, 1'b1, 10, 3);

        // Zero output channels: straight to DONE with the error flag.
        send_cfg(3, 0, 20, 20, 1'b0);
        check("err_config_prep", 32'(data_prepare_o), 32'd0);
        check("err_config_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("err_done", 32'(conv_completed_o), 32'd1);
        check("err_flag", 32'(cfg_err_o), 32'd1);
        check("err_prep", 32'(data_prepare_o), 32'd0);
        check("err_passes", 32'(pass_count_o), 32'd0);

        // New cfg from DONE clears completion and error.
        push_passes(1, 4);
        send_cfg(1, 4, 8, 8, 1'b1);
        check("redo_completed_drop", 32'(conv_completed_o), 32'd0);
        check("redo_err_clear", 32'(cfg_err_o), 32'd0);
        for (int p = 0; p < 2; p++) begin
            wait_prepare();
            pop_compare("redo_pass");
            loop_finished_i = 1'b1;
            @(negedge clk);
            loop_finished_i = 1'b0;
        end
        @(negedge clk);
        check("redo_done", 32'(conv_completed_o), 32'd1);
        check("redo_count", 32'(pass_count_o), 32'd2);

        // Abort during the third PREPARE.
        push_passes(2, 5);
        send_cfg(2, 5, 13, 7, 1'b1);
        for (int p = 0; p < 2; p++) begin
            wait_prepare();
            pop_compare("abort_pass");
            loop_finished_i = 1'b1;
            @(negedge clk);
            loop_finished_i = 1'b0;
        end
        wait_prepare();
        pop_compare("abort_pass3");
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        sb.delete();
        check("abort_idle", {cfg_ready_o, busy_o, conv_completed_o}, 32'b100);
        check("abort_clear", {pass_count_o, weight_od_base_o, 4'b0, weight_id_o}, 32'd0);
        run_cfg(2, 3, 9, 9, 1'b0, 2, 2);

        // loop_finished held high: one pass every two cycles.
        push_passes(2, 4);
        send_cfg(2, 4, 10, 10, 1'b1);
        loop_finished_i = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            check("hold_prepare", 32'(data_prepare_o), 32'((c % 2) == 0));
            if ((c % 2) == 0) pop_compare("hold_pass");
            @(negedge clk);
        end
        check("hold_done", 32'(conv_completed_o), 32'd1);
        check("hold_count", 32'(pass_count_o), 32'd4);

        // Asynchronous reset in the middle of a run.
        send_cfg(2, 4, 30, 30, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_ready", 32'(cfg_ready_o), 32'd1);
        check("areset_outs", {busy_o, data_prepare_o, conv_completed_o, cfg_err_o, size_type_o,
                              od_lane_mask_o, weight_id_o, data_id_o}, 32'd0);
        check("areset_cnt", {pass_count_o, block_width_o, block_height_o}, 32'd0);
        check("areset_odbase", 32'(weight_od_base_o), 32'd0);
        loop_finished_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
